// File: rtl/organ_pkg.sv
// Shared organ definitions: PS/2 set-2 make codes and the key-repeat phase type.
package organ_pkg;

    localparam logic [7:0] ps2_none   = 8'h00;
    localparam logic [7:0] ps2_lshift = 8'h12;
    localparam logic [7:0] ps2_rshift = 8'h59;
    localparam logic [7:0] ps2_ctrl   = 8'h14;
    localparam logic [7:0] ps2_space  = 8'h29;
    localparam logic [7:0] ps2_comma  = 8'h41;
    localparam logic [7:0] ps2_period = 8'h49;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } rpt_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Key edge detector with hold-to-repeat: fires once on a new press, then after
// REPEAT_DELAY held cycles, then every REPEAT_PERIOD cycles. Space never repeats.
module key_repeat
    import organ_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_key,
    output logic       o_fire,
    output logic [7:0] o_fire_key
);

    localparam int unsigned CntMax = max_u(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] DelayLast  = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] PeriodLast = CntW'(REPEAT_PERIOD - 1);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);

    logic [7:0]      r_key;
    rpt_state_e      r_state;
    logic [CntW-1:0] r_cnt;

    rpt_state_e      w_state_n;
    logic [CntW-1:0] w_cnt_n;
    logic            w_new_press;
    logic            w_tick;

    always_comb begin
        w_new_press = (i_key != ps2_none) && (i_key != r_key);
        w_tick      = 1'b0;
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;

        if (i_key == ps2_none) begin
            w_state_n = StIdle;
            w_cnt_n   = '0;
        end else if (w_new_press) begin
            w_state_n = StDelay;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                StDelay: begin
                    if (r_cnt == DelayLast) begin
                        w_tick    = 1'b1;
                        w_state_n = StRepeat;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt + CntOne;
                    end
                end
                StRepeat: begin
                    if (r_cnt == PeriodLast) begin
                        w_tick  = 1'b1;
                        w_cnt_n = '0;
                    end else begin
                        w_cnt_n = r_cnt + CntOne;
                    end
                end
                default: begin
                end
            endcase
        end

        o_fire     = w_new_press || (w_tick && (i_key != ps2_space));
        o_fire_key = i_key;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_key   <= ps2_none;
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_key   <= i_key;
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

endmodule

// File: rtl/octave_transpose_ctrl.sv
// Keyboard-driven octave offset and semitone transpose with saturation or
// semitone-to-octave carry, plus a one-cycle change pulse for the lookup stage.
module octave_transpose_ctrl
    import organ_pkg::*;
#(
    parameter int          OCT_W         = 3,
    parameter int          OCT_MIN       = -2,
    parameter int          OCT_MAX       = 2,
    parameter int          SEMI_W        = 5,
    parameter int          SEMI_MAX      = 11,
    parameter int          CARRY         = 0,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_key,
    output logic signed [OCT_W-1:0]  o_octave,
    output logic signed [SEMI_W-1:0] o_semitone,
    output logic                     o_changed,
    output logic                     o_oct_at_max,
    output logic                     o_oct_at_min
);

    if (OCT_MIN > 0 || OCT_MAX < 0) begin : g_chk_oct_order
        $error("octave range must contain zero");
    end
    if (OCT_MIN < -(2 ** (OCT_W - 1)) || OCT_MAX > (2 ** (OCT_W - 1)) - 1) begin : g_chk_oct_w
        $error("octave limits not representable in OCT_W bits");
    end
    if (SEMI_MAX < 0 || SEMI_MAX > (2 ** (SEMI_W - 1)) - 1) begin : g_chk_semi_w
        $error("SEMI_MAX not representable in SEMI_W bits");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_chk_repeat
        $error("repeat intervals must be at least one cycle");
    end

    // One extra bit of headroom so +/-1 on a limit value can never wrap.
    localparam logic signed [OCT_W:0]  OctMaxX  = (OCT_W + 1)'(OCT_MAX);
    localparam logic signed [OCT_W:0]  OctMinX  = (OCT_W + 1)'(OCT_MIN);
    localparam logic signed [OCT_W:0]  OctOne   = (OCT_W + 1)'(1);
    localparam logic signed [SEMI_W:0] SemiMaxX = (SEMI_W + 1)'(SEMI_MAX);
    localparam logic signed [SEMI_W:0] SemiMinX = (SEMI_W + 1)'(-SEMI_MAX);
    localparam logic signed [SEMI_W:0] SemiOne  = (SEMI_W + 1)'(1);

    logic signed [OCT_W-1:0]  r_octave;
    logic signed [SEMI_W-1:0] r_semitone;
    logic                     r_changed;

    logic                     w_fire;
    logic [7:0]               w_fire_key;
    logic signed [OCT_W:0]    w_oct_x;
    logic signed [SEMI_W:0]   w_semi_x;
    logic signed [OCT_W:0]    w_oct_n;
    logic signed [SEMI_W:0]   w_semi_n;
    logic                     w_changed_n;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_key_repeat (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_key     (i_key),
        .o_fire    (w_fire),
        .o_fire_key(w_fire_key)
    );

    always_comb begin
        w_oct_x  = {r_octave[OCT_W-1], r_octave};
        w_semi_x = {r_semitone[SEMI_W-1], r_semitone};
        w_oct_n  = w_oct_x;
        w_semi_n = w_semi_x;

        if (w_fire) begin
            case (w_fire_key)
                ps2_lshift, ps2_rshift: begin
                    if (w_oct_x != OctMaxX) w_oct_n = w_oct_x + OctOne;
                end
                ps2_ctrl: begin
                    if (w_oct_x != OctMinX) w_oct_n = w_oct_x - OctOne;
                end
                ps2_period: begin
                    if (w_semi_x != SemiMaxX) begin
                        w_semi_n = w_semi_x + SemiOne;
                    end else if (CARRY != 0 && w_oct_x != OctMaxX) begin
                        w_semi_n = '0;
                        w_oct_n  = w_oct_x + OctOne;
                    end
                end
                ps2_comma: begin
                    if (w_semi_x != SemiMinX) begin
                        w_semi_n = w_semi_x - SemiOne;
                    end else if (CARRY != 0 && w_oct_x != OctMinX) begin
                        w_semi_n = '0;
                        w_oct_n  = w_oct_x - OctOne;
                    end
                end
                ps2_space: begin
                    w_oct_n  = '0;
                    w_semi_n = '0;
                end
                default: begin
                end
            endcase
        end

        w_changed_n = (w_oct_n != w_oct_x) || (w_semi_n != w_semi_x);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_octave   <= '0;
            r_semitone <= '0;
            r_changed  <= 1'b0;
        end else begin
            r_octave   <= w_oct_n[OCT_W-1:0];
            r_semitone <= w_semi_n[SEMI_W-1:0];
            r_changed  <= w_changed_n;
        end
    end

    assign o_octave     = r_octave;
    assign o_semitone   = r_semitone;
    assign o_changed    = r_changed;
    assign o_oct_at_max = (w_oct_x == OctMaxX);
    assign o_oct_at_min = (w_oct_x == OctMinX);

endmodule

// File: doc/octave_transpose_ctrl.md
Name: octave_transpose_ctrl

Overview:
Keyboard-driven pitch-offset controller for the organ datapath. Consumes 8-bit PS/2 key codes and maintains a signed octave offset plus a signed semitone transpose, both with saturation (or semitone-to-octave carry), edge-detected key events and hold-to-repeat. Sits between the PS/2 decoder and the note-frequency lookup; it is the parametrised successor to the fixed 2-bit wrapping octave register.

Parameters:
OCT_W, 3, octave output width (signed)
OCT_MIN, -2, lowest octave offset; saturation floor
OCT_MAX, 2, highest octave offset; saturation ceiling
SEMI_W, 5, semitone output width (signed)
SEMI_MAX, 11, semitone range is -SEMI_MAX..+SEMI_MAX
CARRY, 0, 0 = semitone saturates at the range limits; 1 = semitone overflow carries into octave
REPEAT_DELAY, 50_000_000, cycles a key is held before the first auto-repeat
REPEAT_PERIOD, 10_000_000, cycles between subsequent auto-repeats

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key  in  8  current PS/2 make code; 8'h00 = no key
octave  out  OCT_W  signed octave offset
semitone  out  SEMI_W  signed semitone transpose
changed  out  1  one-cycle pulse: octave or semitone changed on the previous edge
oct_at_max  out  1  octave == OCT_MAX
oct_at_min  out  1  octave == OCT_MIN

Behaviour:
- Reset (rst=1 at posedge, priority over everything): octave=0, semitone=0, changed=0, key_q=0, repeat counter=0, repeat phase=IDLE.
- key_q registers key every cycle. Step event ("fire") occurs at an edge where key!=0 and key!=key_q (new press), or on an auto-repeat tick. Held key with no tick = no action (no per-cycle stepping).
- Repeat FSM: IDLE -> DELAY on new press (counter cleared); DELAY: count, at REPEAT_DELAY-1 fire, -> REPEAT, clear; REPEAT: fire every REPEAT_PERIOD cycles. key==0 -> IDLE. key changes to another nonzero code -> new press, DELAY restarts.
- Space does not auto-repeat (repeat ticks for ps2_space ignored).
- Actions on fire (applied at that same edge; outputs valid after it):
  ps2_lshift / ps2_rshift: octave+1 unless octave==OCT_MAX (hold).
  ps2_ctrl: octave-1 unless octave==OCT_MIN (hold).
  ps2_period: semitone+1; ps2_comma: semitone-1.
  ps2_space: octave=0, semitone=0.
  any other code: no change.
- Semitone limits, CARRY=0: saturate at +/-SEMI_MAX.
- CARRY=1: +1 at +SEMI_MAX -> semitone=0, octave+1; -1 at -SEMI_MAX -> semitone=0, octave-1. If the octave is at the corresponding limit, neither value changes.
- Arithmetic in OCT_W+1 / SEMI_W+1 bit signed intermediates; never wraps.
- changed=1 for exactly the cycle after an edge where (octave, semitone) actually changed; saturated/held steps and space at (0,0) give changed=0.
- oct_at_max/oct_at_min combinational from the octave register.
- Reset mid-hold: state cleared; if key is still held after reset releases, it counts as a new press (key_q=0).
- Elaboration checks: OCT_MIN<=0<=OCT_MAX, both representable in OCT_W; SEMI_MAX representable in SEMI_W; REPEAT_DELAY, REPEAT_PERIOD >= 1. Counter width = $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).

Decomposition:
- Shared package organ_pkg: PS/2 set-2 make codes ps2_lshift=8'h12, ps2_rshift=8'h59, ps2_ctrl=8'h14, ps2_space=8'h29, ps2_comma=8'h41, ps2_period=8'h49; repeat-FSM state enum (IDLE, DELAY, REPEAT).
- Sub-module key_repeat (params REPEAT_DELAY, REPEAT_PERIOD; ports clk, rst, key -> fire, fire_key): edge detect + repeat FSM. Top holds the octave/semitone update logic.

Test Plan:
- Reset, then key=8'h12 for 1 cycle, then 8'h00 -> octave=1 after one edge, changed pulses one cycle, semitone=0.
- REPEAT_DELAY=4, REPEAT_PERIOD=2; hold 8'h12 for 12 cycles from octave=0 -> steps 0->1->2 then held at 2, oct_at_max=1, changed only on the two real changes.
- Press ps2_ctrl 5 times from 0 (released between presses) -> octave -1,-2,-2,-2,-2; oct_at_min=1.
- CARRY=0: 13 presses of 8'h49 -> semitone saturates at 11; then 8'h29 -> octave=0, semitone=0, changed=1.
- CARRY=1, octave=0, semitone=11: press 8'h49 -> octave=1, semitone=0; at octave=2, semitone=11, press 8'h49 -> no change, changed=0.
- Hold 8'h12, assert rst for 1 cycle mid-DELAY, keep key held -> octave=0 at reset, then 1 on the first edge after rst deasserts (new press).
